// File: rtl/tcp_tx_session_gate_if.sv
`default_nettype none
// ============================================================================
// tcp_tx_session_gate_if : handshake bundle between application, gate and TOE
// Revision: 1.0
// ============================================================================
interface tcp_tx_session_gate_if #(
  parameter int unsigned DATA_WIDTH = 512
);
  logic                    listen_port_valid;
  logic                    listen_port_ready;
  logic [15:0]             listen_port_data;
  logic                    listen_status_valid;
  logic                    listen_status_ready;
  logic [7:0]              listen_status_data;
  logic                    in_meta_valid;
  logic                    in_meta_ready;
  logic [31:0]             in_meta_data;
  logic                    in_data_valid;
  logic                    in_data_ready;
  logic [DATA_WIDTH-1:0]   in_data_data;
  logic [DATA_WIDTH/8-1:0] in_data_keep;
  logic                    in_data_last;
  logic                    tx_meta_valid;
  logic                    tx_meta_ready;
  logic [31:0]             tx_meta_data;
  logic                    tx_status_valid;
  logic                    tx_status_ready;
  logic [63:0]             tx_status_data;
  logic                    tx_data_valid;
  logic                    tx_data_ready;
  logic [DATA_WIDTH-1:0]   tx_data_data;
  logic [DATA_WIDTH/8-1:0] tx_data_keep;
  logic                    tx_data_last;

  // master: application + TOE environment side
  modport master (
    input  listen_port_valid, listen_port_data, listen_status_ready,
           in_meta_ready, in_data_ready,
           tx_meta_valid, tx_meta_data, tx_status_ready,
           tx_data_valid, tx_data_data, tx_data_keep, tx_data_last,
    output listen_port_ready, listen_status_valid, listen_status_data,
           in_meta_valid, in_meta_data,
           in_data_valid, in_data_data, in_data_keep, in_data_last,
           tx_meta_ready, tx_status_valid, tx_status_data, tx_data_ready
  );

  // slave: the gate itself
  modport slave (
    output listen_port_valid, listen_port_data, listen_status_ready,
           in_meta_ready, in_data_ready,
           tx_meta_valid, tx_meta_data, tx_status_ready,
           tx_data_valid, tx_data_data, tx_data_keep, tx_data_last,
    input  listen_port_ready, listen_status_valid, listen_status_data,
           in_meta_valid, in_meta_data,
           in_data_valid, in_data_data, in_data_keep, in_data_last,
           tx_meta_ready, tx_status_valid, tx_status_data, tx_data_ready
  );
endinterface
`default_nettype wire

// File: rtl/tcp_tx_session_gate.sv
`default_nettype none
// ============================================================================
// tcp_tx_session_gate : listen bring-up, per-packet TOE metadata/status, verdict-gated data
// Revision: 1.0
// ============================================================================
module tcp_tx_session_gate #(
  parameter int unsigned DATA_WIDTH        = 512,
  parameter int unsigned TOKEN_DEPTH_BITS  = 3,
  parameter logic [15:0] LISTEN_PORT       = 16'h0B48,
  parameter int unsigned LISTEN_DELAY_BITS = 15,
  parameter int unsigned RETRY_LIMIT       = 4,
  parameter int unsigned RETRY_WAIT        = 64
) (
  input  wire logic            clk,
  input  wire logic            rst,
  tcp_tx_session_gate_if.slave bus,
  output logic                 port_open,
  output logic [31:0]          stat_sent_pkts,
  output logic [31:0]          stat_dropped_pkts
);

  localparam int unsigned c_depth   = 1 << TOKEN_DEPTH_BITS;
  localparam int unsigned c_cnt_w   = TOKEN_DEPTH_BITS + 1;
  localparam int unsigned c_lcnt_w  = LISTEN_DELAY_BITS + 1;
  localparam int unsigned c_retry_w = (RETRY_LIMIT > 0) ? $clog2(RETRY_LIMIT + 1) : 1;
  localparam int unsigned c_bo_w    = (RETRY_WAIT > 1) ? $clog2(RETRY_WAIT) : 1;
  localparam logic [c_cnt_w-1:0]   c_full        = c_cnt_w'(c_depth);
  localparam logic [c_retry_w-1:0] c_retry_limit = c_retry_w'(RETRY_LIMIT);
  localparam logic [c_bo_w-1:0]    c_bo_last     = (RETRY_WAIT > 0) ? c_bo_w'(RETRY_WAIT - 1) : '0;

  typedef enum logic [1:0] {L_WAIT = 2'd0, L_REQ = 2'd1, L_STAT = 2'd2, L_DONE = 2'd3} listen_state_e;
  typedef enum logic [1:0] {M_IDLE = 2'd0, M_SEND = 2'd1, M_WAIT = 2'd2, M_BACK = 2'd3} meta_state_e;

  listen_state_e               l_state_q, l_state_d;
  logic [c_lcnt_w-1:0]         l_cnt_q, l_cnt_d;
  meta_state_e                 m_state_q, m_state_d;
  logic [31:0]                 meta_q, meta_d;
  logic [c_retry_w-1:0]        retry_q, retry_d;
  logic [c_bo_w-1:0]           bo_q, bo_d;
  logic [c_depth-1:0]          mem_q, mem_d;
  logic [TOKEN_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [c_cnt_w-1:0]          cnt_q, cnt_d;
  logic [31:0]                 sent_q, sent_d, dropped_q, dropped_d;

  logic                        w_push, w_push_verdict, w_pop, w_head;
  logic                        w_fifo_empty, w_fifo_full;
  logic                        w_in_meta_ready, w_in_data_ready, w_tx_data_valid;
  logic [1:0]                  w_status_code;
  logic [DATA_WIDTH-1:0]       w_data;
  logic [DATA_WIDTH/8-1:0]     w_keep;
  logic                        w_unused;

  assign w_status_code = bus.tx_status_data[63:62];
  assign w_unused      = ^{bus.listen_status_data[7:1], bus.tx_status_data[61:0]};

  // ---------------- listen bring-up ----------------
  always_comb begin
    l_state_d = l_state_q;
    l_cnt_d   = l_cnt_q;
    case (l_state_q)
      L_WAIT: begin
        l_cnt_d = l_cnt_q + c_lcnt_w'(1);
        if (l_cnt_d[LISTEN_DELAY_BITS]) l_state_d = L_REQ;
      end
      L_REQ: if (bus.listen_port_ready) l_state_d = L_STAT;
      L_STAT: begin
        if (bus.listen_status_valid) begin
          if (bus.listen_status_data[0]) begin
            l_state_d = L_DONE;
          end else begin
            l_cnt_d   = '0;
            l_state_d = L_WAIT;
          end
        end
      end
      default: l_state_d = L_DONE;
    endcase
  end

  // ---------------- per-packet metadata / status ----------------
  always_comb begin
    m_state_d       = m_state_q;
    meta_d          = meta_q;
    retry_d         = retry_q;
    bo_d            = bo_q;
    w_push          = 1'b0;
    w_push_verdict  = 1'b0;
    w_in_meta_ready = 1'b0;
    case (m_state_q)
      M_IDLE: begin
        if (bus.in_meta_valid && !w_fifo_full) begin
          w_in_meta_ready = 1'b1;
          meta_d          = bus.in_meta_data;
          retry_d         = '0;
          m_state_d       = M_SEND;
        end
      end
      M_SEND: if (bus.tx_meta_ready) m_state_d = M_WAIT;
      M_WAIT: begin
        if (bus.tx_status_valid) begin
          m_state_d = M_IDLE;
          if (w_status_code == 2'd0) begin
            w_push         = 1'b1;
            w_push_verdict = 1'b1;
          end else if (w_status_code == 2'd2 && retry_q != c_retry_limit) begin
            retry_d   = retry_q + c_retry_w'(1);
            bo_d      = '0;
            m_state_d = M_BACK;
          end else begin
            w_push = 1'b1;
          end
        end
      end
      default: begin
        if (bo_q == c_bo_last) m_state_d = M_SEND;
        else                   bo_d      = bo_q + c_bo_w'(1);
      end
    endcase
  end

  // ---------------- verdict FIFO + gated data path ----------------
  assign w_fifo_empty = (cnt_q == '0);
  assign w_fifo_full  = (cnt_q == c_full);
  assign w_head       = mem_q[rd_ptr_q];

  // PASS head forwards with TOE backpressure; DROP head sinks beats unconditionally
  always_comb begin
    w_tx_data_valid = 1'b0;
    w_in_data_ready = 1'b0;
    if (!w_fifo_empty) begin
      if (w_head) begin
        w_tx_data_valid = bus.in_data_valid;
        w_in_data_ready = bus.tx_data_ready;
      end else begin
        w_in_data_ready = 1'b1;
      end
    end
  end

  assign w_pop = !w_fifo_empty && bus.in_data_valid && w_in_data_ready && bus.in_data_last;

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    sent_d    = sent_q;
    dropped_d = dropped_q;
    if (w_push && !w_fifo_full) begin
      mem_d[wr_ptr_q] = w_push_verdict;
      wr_ptr_d        = wr_ptr_q + TOKEN_DEPTH_BITS'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + TOKEN_DEPTH_BITS'(1);
      if (w_head) sent_d    = sent_q + 32'd1;
      else        dropped_d = dropped_q + 32'd1;
    end
    case ({w_push && !w_fifo_full, w_pop})
      2'b10:   cnt_d = cnt_q + c_cnt_w'(1);
      2'b01:   cnt_d = cnt_q - c_cnt_w'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      l_state_q <= L_WAIT;
      l_cnt_q   <= '0;
      m_state_q <= M_IDLE;
      meta_q    <= '0;
      retry_q   <= '0;
      bo_q      <= '0;
      mem_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      sent_q    <= '0;
      dropped_q <= '0;
    end else begin
      l_state_q <= l_state_d;
      l_cnt_q   <= l_cnt_d;
      m_state_q <= m_state_d;
      meta_q    <= meta_d;
      retry_q   <= retry_d;
      bo_q      <= bo_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      sent_q    <= sent_d;
      dropped_q <= dropped_d;
    end
  end

  assign w_data = bus.in_data_data;
  assign w_keep = bus.in_data_keep;

  assign bus.listen_port_valid   = (l_state_q == L_REQ);
  assign bus.listen_port_data    = (l_state_q == L_REQ) ? LISTEN_PORT : 16'h0000;
  assign bus.listen_status_ready = 1'b1;
  assign bus.in_meta_ready       = w_in_meta_ready;
  assign bus.tx_meta_valid       = (m_state_q == M_SEND);
  assign bus.tx_meta_data        = meta_q;
  assign bus.tx_status_ready     = 1'b1;
  assign bus.in_data_ready       = w_in_data_ready;
  assign bus.tx_data_valid       = w_tx_data_valid;
  assign bus.tx_data_data        = w_data;
  assign bus.tx_data_keep        = w_keep;
  assign bus.tx_data_last        = bus.in_data_last;

  assign port_open         = (l_state_q == L_DONE);
  assign stat_sent_pkts    = sent_q;
  assign stat_dropped_pkts = dropped_q;

endmodule
`default_nettype wire
